// File: rtl/sha256_pkg.sv
// Shared definitions for the iterative SHA-256 round core.
// Holds the round count, the IV constants, the FSM state encoding and the compression
// helper functions. The round-constant table lives in sha256_k_rom.
// Optional feed-forward is selected elsewhere with `SHA256_FEEDFORWARD_EN.
package sha256_pkg;

   localparam int unsigned Rounds    = 64;
   localparam logic [5:0]  LastRound = 6'(Rounds - 1);

   // Standard initial hash value {H0..H7}, H0 in the top word
   localparam logic [255:0] Iv = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                  32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

   typedef enum logic [1:0] {
      StIdle,
      StRound,
      StFinal
   } state_e;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] big_sigma0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] big_sigma1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                      input logic [31:0] g);
      return (e & f) ^ (~e & g);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] c);
      return (a & b) ^ (a & c) ^ (b & c);
   endfunction

endpackage

// File: rtl/sha256_round_core_stream_if.sv
// Handshake and data bundle between the W-schedule pipeline / control and the round core.
// master drives start, chaining input and the W stream; slave is the round core.
interface sha256_round_core_stream_if;

   logic         start;
   logic [255:0] h_in;
   logic         w_valid;
   logic [31:0]  w_in;
   logic         w_ready;
   logic [255:0] hash_out;
   logic         busy;
   logic         done;

   modport master (
      output start, h_in, w_valid, w_in,
      input  w_ready, hash_out, busy, done
   );

   modport slave (
      input  start, h_in, w_valid, w_in,
      output w_ready, hash_out, busy, done
   );

endinterface

// File: rtl/sha256_k_rom.sv
// SHA-256 round-constant ROM: round index in, K[round] out, purely combinational.
module sha256_k_rom (
   input  logic [5:0]  round,
   output logic [31:0] k
);

   // Constant lookup table
   always_comb begin
      k = '0;
      case (round)
         6'd0:  k = 32'h428a2f98;  6'd1:  k = 32'h71374491;
         6'd2:  k = 32'hb5c0fbcf;  6'd3:  k = 32'he9b5dba5;
         6'd4:  k = 32'h3956c25b;  6'd5:  k = 32'h59f111f1;
         6'd6:  k = 32'h923f82a4;  6'd7:  k = 32'hab1c5ed5;
         6'd8:  k = 32'hd807aa98;  6'd9:  k = 32'h12835b01;
         6'd10: k = 32'h243185be;  6'd11: k = 32'h550c7dc3;
         6'd12: k = 32'h72be5d74;  6'd13: k = 32'h80deb1fe;
         6'd14: k = 32'h9bdc06a7;  6'd15: k = 32'hc19bf174;
         6'd16: k = 32'he49b69c1;  6'd17: k = 32'hefbe4786;
         6'd18: k = 32'h0fc19dc6;  6'd19: k = 32'h240ca1cc;
         6'd20: k = 32'h2de92c6f;  6'd21: k = 32'h4a7484aa;
         6'd22: k = 32'h5cb0a9dc;  6'd23: k = 32'h76f988da;
         6'd24: k = 32'h983e5152;  6'd25: k = 32'ha831c66d;
         6'd26: k = 32'hb00327c8;  6'd27: k = 32'hbf597fc7;
         6'd28: k = 32'hc6e00bf3;  6'd29: k = 32'hd5a79147;
         6'd30: k = 32'h06ca6351;  6'd31: k = 32'h14292967;
         6'd32: k = 32'h27b70a85;  6'd33: k = 32'h2e1b2138;
         6'd34: k = 32'h4d2c6dfc;  6'd35: k = 32'h53380d13;
         6'd36: k = 32'h650a7354;  6'd37: k = 32'h766a0abb;
         6'd38: k = 32'h81c2c92e;  6'd39: k = 32'h92722c85;
         6'd40: k = 32'ha2bfe8a1;  6'd41: k = 32'ha81a664b;
         6'd42: k = 32'hc24b8b70;  6'd43: k = 32'hc76c51a3;
         6'd44: k = 32'hd192e819;  6'd45: k = 32'hd6990624;
         6'd46: k = 32'hf40e3585;  6'd47: k = 32'h106aa070;
         6'd48: k = 32'h19a4c116;  6'd49: k = 32'h1e376c08;
         6'd50: k = 32'h2748774c;  6'd51: k = 32'h34b0bcb5;
         6'd52: k = 32'h391c0cb3;  6'd53: k = 32'h4ed8aa4a;
         6'd54: k = 32'h5b9cca4f;  6'd55: k = 32'h682e6ff3;
         6'd56: k = 32'h748f82ee;  6'd57: k = 32'h78a5636f;
         6'd58: k = 32'h84c87814;  6'd59: k = 32'h8cc70208;
         6'd60: k = 32'h90befffa;  6'd61: k = 32'ha4506ceb;
         6'd62: k = 32'hbef9a3f7;  6'd63: k = 32'hc67178f2;
         default: k = '0;
      endcase
   end

endmodule

// File: rtl/sha256_round_core_stream.sv
// Iterative SHA-256 compression core fed by the W-schedule stream, one round per accepted
// beat. Define SHA256_FEEDFORWARD_EN to add the chaining input back into the result here;
// otherwise the raw working variables {a..h} are output and the feed-forward adder is shared
// outside this block.
module sha256_round_core_stream
   import sha256_pkg::*;
(
   input logic                       CLK,
   input logic                       RST,
   sha256_round_core_stream_if.slave bus
);

   state_e        state_q, state_d;
   logic [5:0]    round_q, round_d;
   logic [31:0]   a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q;
   logic [31:0]   a_d, b_d, c_d, d_d, e_d, f_d, g_d, h_d;
   logic [255:0]  hash_q, hash_d, result;
   logic          done_q, done_d;
   logic          w_ready;
   logic [31:0]   k, t1, t2;
`ifdef SHA256_FEEDFORWARD_EN
   logic [255:0]  hin_q, hin_d;
`endif

   sha256_k_rom u_k_rom (
      .round (round_q),
      .k     (k)
   );

   // One compression round from the current working variables and the offered word
   always_comb begin
      t1 = h_q + big_sigma1(e_q) + ch(e_q, f_q, g_q) + k + bus.w_in;
      t2 = big_sigma0(a_q) + maj(a_q, b_q, c_q);
   end

   // Block result: fed-forward chaining value or raw working variables
   always_comb begin
`ifdef SHA256_FEEDFORWARD_EN
      result = {hin_q[255:224] + a_q, hin_q[223:192] + b_q, hin_q[191:160] + c_q,
                hin_q[159:128] + d_q, hin_q[127:96]  + e_q, hin_q[95:64]   + f_q,
                hin_q[63:32]   + g_q, hin_q[31:0]    + h_q};
`else
      result = {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q};
`endif
   end

   // FSM next-state, datapath next-state and handshake output
   always_comb begin
      state_d = state_q;
      round_d = round_q;
      {a_d, b_d, c_d, d_d, e_d, f_d, g_d, h_d} = {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q};
      hash_d  = hash_q;
      done_d  = 1'b0;
      w_ready = 1'b0;
`ifdef SHA256_FEEDFORWARD_EN
      hin_d   = hin_q;
`endif
      case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d = StRound;
               round_d = '0;
               {a_d, b_d, c_d, d_d, e_d, f_d, g_d, h_d} = bus.h_in;
`ifdef SHA256_FEEDFORWARD_EN
               hin_d   = bus.h_in;
`endif
            end
         end
         StRound: begin
            w_ready = 1'b1;
            // Without a beat everything holds: stalls may last indefinitely
            if (bus.w_valid) begin
               {b_d, c_d, d_d} = {a_q, b_q, c_q};
               {f_d, g_d, h_d} = {e_q, f_q, g_q};
               e_d     = d_q + t1;
               a_d     = t1 + t2;
               round_d = round_q + 6'd1;
               if (round_q == LastRound) begin
                  state_d = StFinal;
               end
            end
         end
         StFinal: begin
            hash_d  = result;
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers; reset discards any partial block
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= StIdle;
         round_q <= '0;
         {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q} <= '0;
         hash_q  <= '0;
         done_q  <= 1'b0;
`ifdef SHA256_FEEDFORWARD_EN
         hin_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q} <= {a_d, b_d, c_d, d_d, e_d, f_d, g_d, h_d};
         hash_q  <= hash_d;
         done_q  <= done_d;
`ifdef SHA256_FEEDFORWARD_EN
         hin_q   <= hin_d;
`endif
      end
   end

   assign bus.w_ready  = w_ready;
   assign bus.busy     = (state_q != StIdle);
   assign bus.done     = done_q;
   assign bus.hash_out = hash_q;

endmodule

// File: tb/tb_sha256_round_core_stream.sv
// Self-checking bench for sha256_round_core_stream: directed known-answer blocks, stall,
// ignored-start, mid-block reset and back-to-back cases, plus randomized blocks checked
// against a behavioural SHA-256 model. Honours `SHA256_FEEDFORWARD_EN like the design.
module tb_sha256_round_core_stream;

   typedef logic [31:0] words_t [64];
   typedef logic [31:0] blk_t [16];

   localparam logic [31:0] KT [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
      32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
      32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
      32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
      32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
      32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                  32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
   localparam logic [255:0] DIGEST_ABC =
      256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] DIGEST_EMPTY =
      256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   always #5 CLK = ~CLK;

   sha256_round_core_stream_if bus ();

   sha256_round_core_stream dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   logic [255:0] exp_hash_q [$];
   int           exp_cyc_q  [$];

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   // ---------------- behavioural reference ----------------
   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic words_t expand(input blk_t b);
      words_t w;
      for (int t = 0; t < 16; t++) w[t] = b[t];
      for (int t = 16; t < 64; t++)
         w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
              + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      return w;
   endfunction

   function automatic logic [255:0] ref_hash(input logic [255:0] h, input words_t w);
      logic [31:0] v [8];
      logic [31:0] hw [8];
      logic [31:0] t1, t2;
      logic [255:0] r;
      for (int i = 0; i < 8; i++) begin
         hw[i] = h[255 - 32*i -: 32];
         v[i]  = hw[i];
      end
      for (int t = 0; t < 64; t++) begin
         t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
            + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
         t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
            + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         for (int i = 7; i > 0; i--) v[i] = v[i-1];
         v[4] = v[4] + t1;
         v[0] = t1 + t2;
      end
      for (int i = 0; i < 8; i++) begin
`ifdef SHA256_FEEDFORWARD_EN
         r[255 - 32*i -: 32] = v[i] + hw[i];
`else
         r[255 - 32*i -: 32] = v[i];
`endif
      end
      return r;
   endfunction

   // Expected output for a known digest computed from the IV
   function automatic logic [255:0] from_digest(input logic [255:0] d);
      logic [255:0] r;
      for (int i = 0; i < 8; i++) begin
`ifdef SHA256_FEEDFORWARD_EN
         r[255 - 32*i -: 32] = d[255 - 32*i -: 32];
`else
         r[255 - 32*i -: 32] = d[255 - 32*i -: 32] - IV[255 - 32*i -: 32];
`endif
      end
      return r;
   endfunction

   // ---------------- monitor / scoreboard ----------------
   always @(negedge CLK) begin
      if (RST && bus.done) begin
         if (exp_hash_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got done=1 at cycle %0d, required no pending block",
                     cyc);
         end else begin
            check("digest", bus.hash_out, exp_hash_q.pop_front());
            check("busy_in_done_cycle", 256'(bus.busy), 256'd0);
            if (exp_cyc_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL done_cycle: got done at cycle %0d, required after all W beats",
                        cyc);
            end else begin
               check("done_cycle", 256'(cyc), 256'(exp_cyc_q.pop_front()));
            end
         end
      end
   end

   // ---------------- driver ----------------
   // mode 0: gap-free, 1: valid toggles 1/0, 2: random gaps
   task automatic send_block(input logic [255:0] h, input words_t w, input int mode,
                             input bit pulse_start, input bit b2b, input int abort_at,
                             input logic [255:0] exp);
      int idx, stalls, k, s;
      bit v, rdy;
      bus.h_in    = h;
      bus.start   = 1'b1;
      bus.w_valid = 1'b1;          // junk offered in IDLE must not be consumed
      bus.w_in    = $urandom;
      @(posedge CLK);
      #1;
      bus.start = 1'b0;
      s = cyc;
      exp_hash_q.push_back(exp);
      idx = 0;
      stalls = 0;
      k = 0;
      while (idx < 64) begin
         if (idx == abort_at) begin
            RST = 1'b0;
            #1;
            check("rst_hash_out", bus.hash_out, 256'd0);
            check("rst_w_ready", 256'(bus.w_ready), 256'd0);
            check("rst_busy", 256'(bus.busy), 256'd0);
            check("rst_done", 256'(bus.done), 256'd0);
            void'(exp_hash_q.pop_back());
            bus.w_valid = 1'b0;
            @(posedge CLK);
            #1;
            RST = 1'b1;
            repeat (3) @(posedge CLK);
            #1;
            return;
         end
         case (mode)
            0:       v = 1'b1;
            1:       v = (k % 2 == 0);
            default: v = ($urandom_range(3) != 0);
         endcase
         bus.start   = pulse_start && (idx == 10 || idx == 40);
         bus.w_valid = v;
         bus.w_in    = v ? w[idx] : $urandom;
         rdy = bus.w_ready;
         @(posedge CLK);
         #1;
         if (v && rdy) idx++;
         else if (!v) stalls++;
         k++;
         if (k > 1000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL beat_budget: got %0d of 64 words accepted, required 64", idx);
            break;
         end
      end
      bus.start   = 1'b0;
      bus.w_valid = 1'b0;
      exp_cyc_q.push_back(s + 65 + stalls);
      if (b2b) begin
         @(posedge CLK);
         #1;
      end else begin
         repeat (3) @(posedge CLK);
         #1;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      blk_t         b_abc, b_empty, b_rand;
      words_t       w_abc, w_empty, w_rand;
      logic [255:0] h_rand;

      b_abc   = '{0: 32'h61626380, 15: 32'h00000018, default: 32'h0};
      b_empty = '{0: 32'h80000000, default: 32'h0};
      w_abc   = expand(b_abc);
      w_empty = expand(b_empty);

      bus.start   = 1'b0;
      bus.h_in    = '0;
      bus.w_valid = 1'b0;
      bus.w_in    = '0;

      #12;
      check("reset_hash_out", bus.hash_out, 256'd0);
      check("reset_w_ready", 256'(bus.w_ready), 256'd0);
      check("reset_busy", 256'(bus.busy), 256'd0);
      check("reset_done", 256'(bus.done), 256'd0);
      @(posedge CLK);
      #1;
      RST = 1'b1;
      @(posedge CLK);
      #1;

      // abc, gap-free
      send_block(IV, w_abc, 0, 1'b0, 1'b0, -1, from_digest(DIGEST_ABC));
      // empty message
      send_block(IV, w_empty, 0, 1'b0, 1'b0, -1, from_digest(DIGEST_EMPTY));
      // abc with valid toggling every cycle
      send_block(IV, w_abc, 1, 1'b0, 1'b0, -1, from_digest(DIGEST_ABC));
      // abc with start pulses mid-block
      send_block(IV, w_abc, 0, 1'b1, 1'b0, -1, from_digest(DIGEST_ABC));
      // reset at round 30, then a fresh abc
      send_block(IV, w_abc, 0, 1'b0, 1'b0, 30, from_digest(DIGEST_ABC));
      send_block(IV, w_abc, 0, 1'b0, 1'b0, -1, from_digest(DIGEST_ABC));
      // back-to-back: second start lands in the done cycle
      send_block(IV, w_abc, 0, 1'b0, 1'b1, -1, from_digest(DIGEST_ABC));
      send_block(IV, w_empty, 0, 1'b0, 1'b0, -1, from_digest(DIGEST_EMPTY));

      // randomized chaining inputs, messages and gaps
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 16; i++) b_rand[i] = $urandom;
         for (int i = 0; i < 8; i++) h_rand[255 - 32*i -: 32] = $urandom;
         w_rand = expand(b_rand);
         send_block(h_rand, w_rand, 2, 1'b0, (r % 2 == 1), -1, ref_hash(h_rand, w_rand));
      end

      for (int i = 0; i < 300 && exp_hash_q.size() != 0; i++) @(posedge CLK);
      if (exp_hash_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: got %0d blocks without done, required 0", exp_hash_q.size());
      end
      repeat (2) @(posedge CLK);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
